result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
Sits directly upstream of the scoreboard and produces its i_freeze and i_diff inputs.
- Buffers golden-model results in a FIFO, because the golden model and the DUT have different latencies.
- Pops one expected value for each DUT result and compares the pair.
- Presents a registered, one-cycle comparison strobe.
- A sticky error state freezes counting if the DUT produces more results than the golden model.

Parameters:
WIDTH, 32, data width of the golden-model and DUT results.
DEPTH_LOG2, 4, log2 of the alignment FIFO depth (depth = 16).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
i_enable  input  1  checker run enable
i_ref_valid  input  1  golden-model result valid
i_ref_data  input  WIDTH  golden-model result
o_ref_ready  output  1  FIFO can accept a golden result
i_dut_valid  input  1  DUT result valid; no backpressure
i_dut_data  input  WIDTH  DUT result
o_freeze  output  1  to scoreboard i_freeze; low only on a compare cycle
o_diff  output  WIDTH  per-bit difference of the last compare
o_diff_any  output  1  to scoreboard i_diff; OR-reduction of o_diff
o_level  output  DEPTH_LOG2+1  current FIFO occupancy
o_underflow  output  1  sticky: DUT result arrived with FIFO empty
o_state  output  2  FSM state, for debug

Behaviour:
- One clock domain. Interface: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values:
  - o_freeze=1, o_diff=0, o_diff_any=0, o_level=0, o_underflow=0, state=IDLE.
  - FIFO pointers cleared; FIFO contents not reset.
- FSM states: IDLE=2'd0, RUN=2'd1, ERROR=2'd2.
  - IDLE -> RUN when i_enable=1.
  - RUN -> IDLE when i_enable=0. FIFO contents and level are retained.
  - RUN -> ERROR on underflow.
  - ERROR is left only by reset; i_enable is ignored in ERROR.
- Push:
  - o_ref_ready = (state==RUN) && (level < 2^DEPTH_LOG2). Combinational from registered state and level.
  - Push occurs iff i_ref_valid && o_ref_ready.
  - Ref data offered while not ready is not accepted; the golden model must hold it.
- Pop/compare:
  - In RUN, i_dut_valid with level>0 pops the head entry.
  - On the next cycle: o_diff = head ^ i_dut_data (registered), o_diff_any = |o_diff, o_freeze=0.
  - Compare latency is exactly 1 cycle from i_dut_valid.
  - On every cycle without a compare, o_freeze=1. o_diff and o_diff_any hold their last values.
- Underflow:
  - i_dut_valid in RUN with level==0 sets o_underflow, moves the FSM to ERROR, and produces no compare (o_freeze stays 1).
  - A push in the same cycle does not rescue it; there is no bypass path.
- Ignored DUT input: i_dut_valid in IDLE or ERROR is dropped. No pop, no flag.
- Simultaneous push and pop:
  - Allowed at any level >0, including full.
  - Level is unchanged; the pop reads the old head.
  - When full, o_ref_ready is still 0, so the push does not occur and level decrements.
- Level arithmetic: level is DEPTH_LOG2+1 bits. Read/write pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight compare output is discarded.

Optional Feature:
Macro CHECKER_ABSDIFF_EN.
- Defined:
  - o_diff = |signed(i_dut_data) - signed(head)|.
  - Computed in WIDTH+1 bits, magnitude taken, result fits WIDTH bits unsigned.
  - o_diff_any = (o_diff != 0).
  - Intended for the scoreboard's max/min error tracking.
- Undefined: o_diff is the bitwise XOR, as above.
- Timing and all other behaviour are identical in both builds.

Test Plan:
1. Reset, then i_enable=1, push refs 5,7,9, then DUT 5,7,9 on consecutive cycles -> three cycles of o_freeze=0, o_diff_any=0; o_level returns to 0.
2. Ref 0x0000_00F0, DUT 0x0000_00FF -> XOR build: o_diff=0x0000_000F, o_diff_any=1. ABSDIFF build: o_diff=15.
3. ABSDIFF build, ref 0x8000_0000, DUT 0x7FFF_FFFF -> o_diff=0xFFFF_FFFF, no overflow.
4. Push 16 refs with DUT idle:
   - o_level=16, o_ref_ready=0, 17th ref held.
   - One DUT pop while 17th valid -> level 15.
   - Next cycle the push is accepted -> level 16.
5. Empty FIFO, DUT valid together with ref valid:
   - o_underflow=1, state=ERROR, o_freeze stays 1.
   - Later i_enable toggles and DUT valids -> no change until reset.
6. Push 3 refs, drop i_enable (IDLE), DUT valid ignored, re-enable -> level still 3; next DUT value compares against the first ref.

Source files
------------

// File: rtl/result_checker.sv
// Aligns golden-model results with DUT results through a FIFO and emits a
// one-cycle compare strobe. Build option CHECKER_ABSDIFF_EN selects |dut-ref| instead of XOR.
//
// state | meaning
// IDLE  | checker stopped; FIFO contents and level retained
// RUN   | accepting golden results, popping and comparing on each DUT result
// ERROR | DUT result seen with an empty FIFO; left only by reset
module result_checker #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_ref_valid,
  input  logic [WIDTH-1:0]      i_ref_data,
  output logic                  o_ref_ready,
  input  logic                  i_dut_valid,
  input  logic [WIDTH-1:0]      i_dut_data,
  output logic                  o_freeze,
  output logic [WIDTH-1:0]      o_diff,
  output logic                  o_diff_any,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_underflow,
  output logic [1:0]            o_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  freeze_q, freeze_d;
  logic [WIDTH-1:0]      diff_q, diff_d;
  logic                  diff_any_q, diff_any_d;
  logic                  underflow_q, underflow_d;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      head;
  logic [WIDTH-1:0]      cmp_diff;
  logic                  ref_ready;
  logic                  push;
  logic                  pop;
  logic                  underflow_evt;

  assign head          = mem[rd_ptr_q];
  assign ref_ready     = (state_q == RUN) && (level_q < FULL_LVL);
  assign push          = i_ref_valid && ref_ready;
  assign pop           = (state_q == RUN) && i_dut_valid && (level_q != '0);
  assign underflow_evt = (state_q == RUN) && i_dut_valid && (level_q == '0);

`ifdef CHECKER_ABSDIFF_EN
  logic signed [WIDTH:0] sub;
  always_comb begin
    // Sign-extend both operands so the difference cannot overflow.
    sub      = $signed({i_dut_data[WIDTH-1], i_dut_data}) - $signed({head[WIDTH-1], head});
    cmp_diff = sub[WIDTH] ? WIDTH'(-sub) : sub[WIDTH-1:0];
  end
`else
  always_comb begin
    cmp_diff = head ^ i_dut_data;
  end
`endif

  always_comb begin
    state_d     = state_q;
    underflow_d = underflow_q;
    unique case (state_q)
      IDLE: begin
        if (i_enable) state_d = RUN;
      end
      RUN: begin
        if (underflow_evt) begin
          state_d     = ERROR;
          underflow_d = 1'b1;
        end else if (!i_enable) begin
          state_d = IDLE;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    freeze_d   = 1'b1;
    diff_d     = diff_q;
    diff_any_d = diff_any_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      freeze_d   = 1'b0;
      diff_d     = cmp_diff;
      diff_any_d = |cmp_diff;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      freeze_q    <= 1'b1;
      diff_q      <= '0;
      diff_any_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      freeze_q    <= freeze_d;
      diff_q      <= diff_d;
      diff_any_q  <= diff_any_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; only the pointers define valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_ref_data;
  end

  assign o_ref_ready = ref_ready;
  assign o_freeze    = freeze_q;
  assign o_diff      = diff_q;
  assign o_diff_any  = diff_any_q;
  assign o_level     = level_q;
  assign o_underflow = underflow_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_result_checker.sv
// Randomized self-checking bench for result_checker against a queue-based model,
// plus directed scenarios with literal expectations.
module tb_result_checker;

  localparam int WIDTH = 32;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_enable = 1'b0;
  logic             i_ref_valid = 1'b0;
  logic [WIDTH-1:0] i_ref_data = '0;
  logic             o_ref_ready;
  logic             i_dut_valid = 1'b0;
  logic [WIDTH-1:0] i_dut_data = '0;
  logic             o_freeze;
  logic [WIDTH-1:0] o_diff;
  logic             o_diff_any;
  logic [DL:0]      o_level;
  logic             o_underflow;
  logic [1:0]       o_state;

  result_checker #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable),
    .i_ref_valid(i_ref_valid), .i_ref_data(i_ref_data), .o_ref_ready(o_ref_ready),
    .i_dut_valid(i_dut_valid), .i_dut_data(i_dut_data),
    .o_freeze(o_freeze), .o_diff(o_diff), .o_diff_any(o_diff_any),
    .o_level(o_level), .o_underflow(o_underflow), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: 0=idle, 1=run, 2=error; FIFO as a queue.
  int               m_state = 0;
  logic [WIDTH-1:0] m_q[$];
  bit               m_freeze = 1'b1;
  logic [WIDTH-1:0] m_diff = '0;
  bit               m_uf = 1'b0;

  function automatic logic [WIDTH-1:0] model_diff(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] d);
`ifdef CHECKER_ABSDIFF_EN
    longint a;
    a = longint'($signed(d)) - longint'($signed(r));
    if (a < 0) a = -a;
    return a[WIDTH-1:0];
`else
    return r ^ d;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_state  = 0;
      m_freeze = 1'b1;
      m_diff   = '0;
      m_uf     = 1'b0;
    end else begin
      bit ready;
      ready    = (m_state == 1) && (m_q.size() < DEPTH);
      m_freeze = 1'b1;
      if (m_state == 1 && i_dut_valid) begin
        if (m_q.size() > 0) begin
          m_diff   = model_diff(m_q.pop_front(), i_dut_data);
          m_freeze = 1'b0;
        end else begin
          m_uf = 1'b1;
        end
      end
      if (i_ref_valid && ready) m_q.push_back(i_ref_data);
      case (m_state)
        0: if (i_enable) m_state = 1;
        1: if (m_uf) m_state = 2; else if (!i_enable) m_state = 0;
        default: m_state = 2;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("freeze",    o_freeze,    m_freeze);
      chk("diff",      o_diff,      m_diff);
      chk("diff_any",  o_diff_any,  m_diff != 0);
      chk("level",     o_level,     m_q.size());
      chk("ref_ready", o_ref_ready, (m_state == 1) && (m_q.size() < DEPTH));
      chk("underflow", o_underflow, m_uf);
      chk("state",     o_state,     m_state);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_enable = 1'b0; i_ref_valid = 1'b0; i_dut_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    i_ref_valid = 1'b1; i_ref_data = v;
    cyc();
    i_ref_valid = 1'b0;
  endtask

  task automatic dutv(input logic [WIDTH-1:0] v);
    i_dut_valid = 1'b1; i_dut_data = v;
    cyc();
    i_dut_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_freeze", o_freeze, 1);
    chk("rst_level", o_level, 0);
    chk("rst_state", o_state, 0);
    chk("rst_diff", o_diff, 0);

    // Matching stream 5,7,9
    i_enable = 1'b1; cyc();
    chk("t1_run", o_state, 1);
    push(5); push(7); push(9);
    chk("t1_level3", o_level, 3);
    i_dut_valid = 1'b1;
    i_dut_data = 5; cyc(); chk("t1_f0", o_freeze, 0); chk("t1_any0", o_diff_any, 0);
    i_dut_data = 7; cyc(); chk("t1_f1", o_freeze, 0); chk("t1_any1", o_diff_any, 0);
    i_dut_data = 9; cyc(); chk("t1_f2", o_freeze, 0); chk("t1_any2", o_diff_any, 0);
    i_dut_valid = 1'b0;
    chk("t1_level0", o_level, 0);
    cyc(); chk("t1_freeze_back", o_freeze, 1);

    // Small difference: same value in both builds
    push(32'h0000_00F0); dutv(32'h0000_00FF);
    chk("t2_diff", o_diff, 32'h0000_000F); chk("t2_any", o_diff_any, 1);
    cyc(); chk("t2_hold", o_diff, 32'h0000_000F);

    // Extreme signed span
    push(32'h8000_0000); dutv(32'h7FFF_FFFF);
    chk("t3_diff", o_diff, 32'hFFFF_FFFF);
    push(3); dutv(5);
`ifdef CHECKER_ABSDIFF_EN
    chk("t3_build", o_diff, 2);
`else
    chk("t3_build", o_diff, 6);
`endif

    // Fill to full, simultaneous pop with held 17th ref
    for (int i = 0; i < DEPTH; i++) push(i * 3 + 1);
    chk("t4_full", o_level, 16); chk("t4_notready", o_ref_ready, 0);
    i_ref_valid = 1'b1; i_ref_data = 32'hAA; cyc();
    chk("t4_held", o_level, 16);
    i_dut_valid = 1'b1; i_dut_data = 1; cyc();
    i_dut_valid = 1'b0;
    chk("t4_pop", o_level, 15); chk("t4_cmp", o_diff_any, 0);
    cyc();
    i_ref_valid = 1'b0;
    chk("t4_refill", o_level, 16);
    for (int i = 0; i < DEPTH; i++) dutv($urandom_range(0, 63));
    chk("t4_drained", o_level, 0);

    // Underflow with simultaneous ref valid
    i_ref_valid = 1'b1; i_ref_data = 1; i_dut_valid = 1'b1; i_dut_data = 1; cyc();
    i_ref_valid = 1'b0; i_dut_valid = 1'b0;
    chk("t5_uf", o_underflow, 1); chk("t5_err", o_state, 2); chk("t5_frz", o_freeze, 1);
    for (int i = 0; i < 6; i++) begin
      i_enable = i[0]; i_dut_valid = 1'b1; i_dut_data = $urandom; cyc();
    end
    i_dut_valid = 1'b0;
    chk("t5_stuck", o_state, 2); chk("t5_uf_stuck", o_underflow, 1);

    // Disable keeps FIFO contents
    do_reset();
    i_enable = 1'b1; cyc();
    push(32'h11); push(32'h22); push(32'h33);
    i_enable = 1'b0; cyc();
    chk("t6_idle", o_state, 0);
    dutv(0);
    chk("t6_level", o_level, 3); chk("t6_nouf", o_underflow, 0); chk("t6_frz", o_freeze, 1);
    i_enable = 1'b1; cyc();
    dutv(32'h11);
    chk("t6_cmp", o_freeze, 0); chk("t6_any", o_diff_any, 0); chk("t6_lvl2", o_level, 2);

    // Randomized traffic, occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      i_enable    = ($urandom_range(0, 19) != 0);
      i_ref_valid = $urandom_range(0, 1);
      i_ref_data  = $urandom_range(0, 3);
      i_dut_valid = ($urandom_range(0, 2) == 0);
      i_dut_data  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3);
      if (m_state == 2 && $urandom_range(0, 9) == 0) reset = 1'b1;
      cyc();
    end
    reset = 1'b0; i_ref_valid = 1'b0; i_dut_valid = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
